fwd_hazard_unit: RTL

Parametrised operand-forwarding and load-use hazard unit for the MIPS pipeline. It keeps a shift-register history of the last DEPTH in-flight register writes, each with its result or a pending-load marker. For every ID/EX source operand it returns the youngest forwarded value, or raises a stall while that value is still an outstanding load. It also completes outstanding loads as memory returns data, and counts stall cycles for performance monitoring.

---
 rtl/fwd_pkg.sv | 23 ++
 rtl/fwd_lookup.sv | 48 ++++
 rtl/fwd_hazard_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the operand-forwarding / load-use hazard unit.
// Struct field widths are the widest datapath this unit is built for.
package fwd_pkg;

    localparam int MAX_DATA_W = 32;
    localparam int MAX_REG_AW = 5;
    localparam int MAX_CNT_W  = 32;
    localparam int ZERO_REG   = 0;

    typedef struct packed {
        logic                  valid;
        logic [MAX_REG_AW-1:0] addr;
        logic [MAX_DATA_W-1:0] data;
        logic                  pending;
    } fwd_entry_t;

    // Increment that sticks at the supplied ceiling instead of wrapping.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] value,
                                                     input logic [MAX_CNT_W-1:0] limit);
        return (value >= limit) ? limit : value + MAX_CNT_W'(1);
    endfunction

endpackage

// File: rtl/fwd_lookup.sv
// One source operand's lookup: youngest matching history entry wins, with a
// bypass of returning load data when that entry is the one being filled now.
module fwd_lookup
    import fwd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int IDX_W  = 2
) (
    input  fwd_entry_t        hist [DEPTH],
    input  logic              fill_valid,
    input  logic [IDX_W-1:0]  fill_idx,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [REG_AW-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data_in,
    output logic [DATA_W-1:0] src_data_out,
    output logic              hazard
);

    logic found;

    // Scan from youngest to oldest; the first hit decides value or stall.
    always_comb begin
        src_data_out = src_data_in;
        hazard       = 1'b0;
        found        = 1'b0;
        if (src_addr == REG_AW'(ZERO_REG)) begin
            src_data_out = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!found && hist[i].valid && (hist[i].addr[REG_AW-1:0] == src_addr)) begin
                    found = 1'b1;
                    if (hist[i].pending) begin
                        if (fill_valid && (fill_idx == IDX_W'(i))) begin
                            src_data_out = ld_data;
                        end else begin
                            hazard = 1'b1;
                        end
                    end else begin
                        src_data_out = hist[i].data[DATA_W-1:0];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding history of in-flight register writes, in-order load completion,
// per-source lookup, stall-cycle counter and sticky lost-load flag.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        advance,
    input  logic                        ex_wr_en,
    input  logic [REG_AW-1:0]           ex_dest,
    input  logic                        ex_is_load,
    input  logic [DATA_W-1:0]           ex_result,
    input  logic                        ld_valid,
    input  logic [DATA_W-1:0]           ld_data,
    input  logic [NUM_SRC*REG_AW-1:0]   src_addr,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data_in,
    output logic [NUM_SRC*DATA_W-1:0]   src_data_out,
    output logic                        hazard_stall,
    output logic [CNT_W-1:0]            stall_count,
    output logic                        ld_overflow
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fwd_entry_t           hist      [DEPTH];
    fwd_entry_t           filled    [DEPTH];
    fwd_entry_t           hist_next [DEPTH];
    fwd_entry_t           new_entry;
    logic                 any_pending;
    logic                 fill_valid;
    logic [IDX_W-1:0]     fill_idx;
    logic [NUM_SRC-1:0]   src_hazard;
    logic                 drop_pending;

    // Oldest valid pending entry is the one the next returning load completes.
    always_comb begin
        any_pending = 1'b0;
        fill_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hist[i].valid && hist[i].pending) begin
                any_pending = 1'b1;
                fill_idx    = IDX_W'(i);
            end
        end
        fill_valid = ld_valid && any_pending;
    end

    // Fill is applied before the shift so it lands on the entry's new position.
    always_comb begin
        new_entry.valid   = ex_wr_en && (ex_dest != REG_AW'(ZERO_REG));
        new_entry.addr    = MAX_REG_AW'(ex_dest);
        new_entry.data    = MAX_DATA_W'(ex_result);
        new_entry.pending = ex_is_load;

        filled = hist;
        if (fill_valid) begin
            filled[fill_idx].data    = MAX_DATA_W'(ld_data);
            filled[fill_idx].pending = 1'b0;
        end

        hist_next = filled;
        if (advance) begin
            hist_next[0] = new_entry;
            for (int i = 1; i < DEPTH; i++) begin
                hist_next[i] = filled[i-1];
            end
        end
    end

    // A still-pending oldest entry leaving the history means a lost load.
    assign drop_pending = advance && hist[DEPTH-1].valid && hist[DEPTH-1].pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist[i] <= '0;
            end
            stall_count <= '0;
            ld_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                hist[i] <= hist_next[i];
            end
            if (hazard_stall) begin
                stall_count <= CNT_W'(sat_inc(MAX_CNT_W'(stall_count), MAX_CNT_W'({CNT_W{1'b1}})));
            end
            if (drop_pending) begin
                ld_overflow <= 1'b1;
            end
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_lookup #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW),
            .DEPTH  (DEPTH),
            .IDX_W  (IDX_W)
        ) u_lookup (
            .hist         (hist),
            .fill_valid   (fill_valid),
            .fill_idx     (fill_idx),
            .ld_data      (ld_data),
            .src_addr     (src_addr[s*REG_AW +: REG_AW]),
            .src_data_in  (src_data_in[s*DATA_W +: DATA_W]),
            .src_data_out (src_data_out[s*DATA_W +: DATA_W]),
            .hazard       (src_hazard[s])
        );
    end

    assign hazard_stall = |src_hazard;

endmodule
